seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//   Time-multiplexed driver for the 4-digit common-anode 7-segment display.
//   Sits directly downstream of the digit-rotation stage and consumes its four 5-bit
//   symbol codes (seg0..seg3).
//   Latches the codes once per frame, decodes each to segment cathodes and scans the
//   anodes one digit at a time with anti-ghosting blanking.
// PARAMETERS
//   REFRESH_DIV  100000  clocks per digit slot (>= BLANK_CYC+2)
//   BLANK_CYC    16      clocks at the start of each slot with all anodes off
// PORTS
//   clk         in   1  system clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   en          in   1  scan enable; low = display dark
//   seg0..seg3  in   5  symbol codes; seg0 = rightmost digit (an[0])
//   dp_in       in   4  decimal point request per digit, 1 = on
//   an          out  4  anode select, active-low, one-hot-low while scanning
//   cat         out  7  cathodes {g,f,e,d,c,b,a}, active-low
//   dp          out  1  decimal-point cathode, active-low
//   frame_tick  out  1  one-clock pulse on every frame start (snapshot load)
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - an=4'b1111, cat=7'h7F, dp=1, frame_tick=0.
//     - State IDLE, prescaler=0, digit index=0.
//     - Snapshot codes=16 (blank), snapshot dp=0.
//   Prescaler: counts 0..REFRESH_DIV-1, then wraps to 0; wrap = slot_end.
//   Digit index: advances 0->1->2->3->0 on slot_end.
//   FSM:
//     IDLE: outputs dark; prescaler and index held at 0. en=1 -> LOAD.
//     LOAD: one clock.
//       - Snapshot seg0..3 and dp_in.
//       - frame_tick=1.
//       - Prescaler=0, index=0.
//       - -> SCAN.
//     SCAN: drive the digit selected by the index.
//       - slot_end with index=3: -> LOAD; the next frame starts on the following clock.
//       - en=0 at any clock: -> IDLE on that edge; outputs dark on the next clock.
//   Frame period: 4*REFRESH_DIV+1 clocks.
//   Inputs are sampled only in LOAD. Changes mid-frame never alter the frame being shown.
//   Outputs are registered and change one clock after the prescaler value that selects them.
//     - Prescaler < BLANK_CYC: an=4'b1111 (cat and dp may already hold the new digit).
//     - Otherwise: an = ~(4'b0001 << index); cat = decode(code[index]); dp = ~dp_snap[index].
//   Decode (active-low):
//     - 0-15: standard hex font (0-9, A, b, C, d, E, F).
//     - 16: blank.
//     - 17: '-' (g only).
//     - 18: H, 19: L, 20: P, 21: U, 22: r, 23: n, 24: o.
//     - 25-31: blank.
//   Boundary conditions:
//     - en drops during LOAD: IDLE wins; the snapshot still completes.
//     - en toggles 1-0-1: always restarts at LOAD with index 0.
//     - Reset mid-frame: immediate dark outputs; no frame_tick until the next LOAD.
//   an never has more than one bit low.
// TESTING
//   1. Reset, then en=1, codes {3,2,1,0}, REFRESH_DIV=8, BLANK_CYC=2
//      -> frame_tick 1 clk after en.
//      -> an walks 1110,1101,1011,0111.
//      -> cat = 7'h40 (0), 7'h79 (1), 7'h24 (2), 7'h30 (3).
//   2. Change seg0 0->8 mid-frame
//      -> digit 0 keeps showing 7'h40 until the next frame_tick.
//      -> then shows 7'h00.
//   3. Codes 16, 17, 15, 31
//      -> cat = 7'h7F, 7'h3F, 7'h0E, 7'h7F.
//      -> dp_in=4'b0100 gives dp=0 only while an=1011.
//   4. Blanking
//      -> an=1111 for exactly BLANK_CYC clocks at the start of every slot.
//      -> one-hot-low an otherwise.
//      -> an is never more than one bit low.
//   5. en=0 in slot 2
//      -> next clock: an=1111, cat=7F, dp=1.
//      -> en=1 again: LOAD, then restart at an=1110.
//   6. Assert rst_n=0 asynchronously mid-slot
//      -> outputs dark before the next clk edge.
//      -> after release with en=1: LOAD, with the snapshot refreshed.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display.
//   Latches the four symbol codes and decimal-point requests once per frame,
//   decodes each code to active-low cathodes and scans the anodes one digit
//   per slot, keeping all anodes off for the first BLANK_CYC clocks of every
//   slot to avoid ghosting.
//
// Parameters
//   REFRESH_DIV  clocks per digit slot (must be >= BLANK_CYC+2)
//   BLANK_CYC    clocks at the start of each slot with all anodes off
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          scan enable; low = display dark
//   seg0..seg3  5-bit symbol codes; seg0 = rightmost digit (an[0])
//   dp_in       decimal point request per digit, 1 = on
//   an          anode select, active-low, one-hot-low while scanning
//   cat         cathodes {g,f,e,d,c,b,a}, active-low
//   dp          decimal-point cathode, active-low
//   frame_tick  one-clock pulse while the snapshot is being loaded

module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [4:0] seg0,
    input  logic [4:0] seg1,
    input  logic [4:0] seg2,
    input  logic [4:0] seg3,
    input  logic [3:0] dp_in,
    output logic [3:0] an,
    output logic [6:0] cat,
    output logic       dp,
    output logic       frame_tick
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PRESC_BLANK = PW'(BLANK_CYC);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SCAN
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [4:0]    code_snap [4];
    logic [3:0]    dp_snap;

    // Active-low segment font, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [4:0] c);
        logic [6:0] s;
        s = 7'h7F;
        case (c)
            5'd0:  s = 7'h40;
            5'd1:  s = 7'h79;
            5'd2:  s = 7'h24;
            5'd3:  s = 7'h30;
            5'd4:  s = 7'h19;
            5'd5:  s = 7'h12;
            5'd6:  s = 7'h02;
            5'd7:  s = 7'h78;
            5'd8:  s = 7'h00;
            5'd9:  s = 7'h10;
            5'd10: s = 7'h08;   // A
            5'd11: s = 7'h03;   // b
            5'd12: s = 7'h46;   // C
            5'd13: s = 7'h21;   // d
            5'd14: s = 7'h06;   // E
            5'd15: s = 7'h0E;   // F
            5'd17: s = 7'h3F;   // '-'
            5'd18: s = 7'h09;   // H
            5'd19: s = 7'h47;   // L
            5'd20: s = 7'h0C;   // P
            5'd21: s = 7'h41;   // U
            5'd22: s = 7'h2F;   // r
            5'd23: s = 7'h2B;   // n
            5'd24: s = 7'h23;   // o
            default: s = 7'h7F; // 16 and 25-31: blank
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            idx        <= '0;
            for (int unsigned i = 0; i < 4; i++) code_snap[i] <= 5'd16;
            dp_snap    <= '0;
            an         <= '1;
            cat        <= '1;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    an         <= '1;
                    cat        <= '1;
                    dp         <= 1'b1;
                    presc      <= '0;
                    idx        <= '0;
                    frame_tick <= 1'b0;
                    if (en) begin
                        state      <= LOAD;
                        frame_tick <= 1'b1;
                    end
                end

                LOAD: begin
                    // Snapshot completes even if en dropped on this clock.
                    code_snap[0] <= seg0;
                    code_snap[1] <= seg1;
                    code_snap[2] <= seg2;
                    code_snap[3] <= seg3;
                    dp_snap      <= dp_in;
                    frame_tick   <= 1'b0;
                    presc        <= '0;
                    idx          <= '0;
                    an           <= '1;
                    cat          <= '1;
                    dp           <= 1'b1;
                    state        <= en ? SCAN : IDLE;
                end

                SCAN: begin
                    frame_tick <= 1'b0;
                    if (!en) begin
                        state <= IDLE;
                        presc <= '0;
                        idx   <= '0;
                        an    <= '1;
                        cat   <= '1;
                        dp    <= 1'b1;
                    end else begin
                        // Cathodes follow the slot immediately; anodes stay off
                        // during the blanking window so the old pattern never
                        // shows on the new digit.
                        an  <= (presc < PRESC_BLANK) ? 4'b1111 : ~(4'b0001 << idx);
                        cat <= decode(code_snap[idx]);
                        dp  <= ~dp_snap[idx];
                        if (presc == PRESC_LAST) begin
                            presc <= '0;
                            idx   <= idx + 2'd1;
                            if (idx == 2'd3) begin
                                state      <= LOAD;
                                frame_tick <= 1'b1;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    an    <= '1;
                    cat   <= '1;
                    dp    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver
//   Scoreboard bench for seg_scan_driver with REFRESH_DIV=8, BLANK_CYC=2.
//   The stimulus process pushes the expected {an,cat,dp} of every lit digit
//   slot; the monitor pops one entry each time a digit lights, checks it stays
//   steady while lit, checks the blanking gap lengths and the one-hot-low rule.

module tb_seg_scan_driver;

    localparam int unsigned DIV   = 8;
    localparam int unsigned BLANK = 2;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [4:0] seg0, seg1, seg2, seg3;
    logic [3:0] dp_in;
    logic [3:0] an;
    logic [6:0] cat;
    logic       dp;
    logic       frame_tick;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] cat;
        logic       dp;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    seg_scan_driver #(
        .REFRESH_DIV(DIV),
        .BLANK_CYC  (BLANK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .seg0      (seg0),
        .seg1      (seg1),
        .seg2      (seg2),
        .seg3      (seg3),
        .dp_in     (dp_in),
        .an        (an),
        .cat       (cat),
        .dp        (dp),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [6:0] c, input logic d);
        exp_t e;
        e.an  = a;
        e.cat = c;
        e.dp  = d;
        q.push_back(e);
    endtask

    task automatic set_codes(input logic [4:0] c0, input logic [4:0] c1,
                             input logic [4:0] c2, input logic [4:0] c3,
                             input logic [3:0] d);
        seg0  = c0;
        seg1  = c1;
        seg2  = c2;
        seg3  = c3;
        dp_in = d;
    endtask

    // Returns at posedge+1 of the clock on which frame_tick is seen.
    task automatic wait_tick(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            #1;
            if (frame_tick === 1'b1) got = 1'b1;
        end
        check(name, 32'(got), 32'd1);
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor
    initial begin
        exp_t        cur;
        exp_t        act;
        logic [3:0]  prev_an;
        int          dark_run;
        bit          saw_tick;
        bit          track;
        prev_an  = 4'hF;
        dark_run = 0;
        saw_tick = 1'b0;
        track    = 1'b0;
        cur      = '0;
        forever begin
            @(posedge clk);
            #1;
            act.an  = an;
            act.cat = cat;
            act.dp  = dp;
            checks++;
            if (!(an === 4'hF || $onehot(~an))) begin
                failures++;
                $display("FAIL an_onehot actual=%b expected=1111_or_one_low", an);
            end
            if (an !== 4'hF) begin
                if (an !== prev_an) begin
                    if (track && prev_an === 4'hF)
                        check("blank_gap", 32'(dark_run),
                              saw_tick ? 32'(BLANK + 1) : 32'(BLANK));
                    checks++;
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_digit actual=%b/%h/%b expected=none", an, cat, dp);
                        cur = act;
                    end else begin
                        cur = q.pop_front();
                        if (act !== cur) begin
                            failures++;
                            $display("FAIL digit actual=%b/%h/%b expected=%b/%h/%b",
                                     act.an, act.cat, act.dp, cur.an, cur.cat, cur.dp);
                        end
                    end
                end else begin
                    check("digit_steady", 32'(act), 32'(cur));
                end
                dark_run = 0;
                saw_tick = frame_tick;
                track    = 1'b1;
            end else begin
                dark_run++;
                if (frame_tick === 1'b1) saw_tick = 1'b1;
            end
            if (en !== 1'b1 || rst_n !== 1'b1) track = 1'b0;
            prev_an = an;
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        set_codes(5'd0, 5'd0, 5'd0, 5'd0, 4'b0000);
        #22;
        check("rst_an", 32'(an), 32'hF);
        check("rst_cat", 32'(cat), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_tick", 32'(frame_tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        skip(3);
        check("idle_an", 32'(an), 32'hF);

        // Frame 1: codes 0,1,2,3
        set_codes(5'd0, 5'd1, 5'd2, 5'd3, 4'b0000);
        push(4'b1110, 7'h40, 1'b1);
        push(4'b1101, 7'h79, 1'b1);
        push(4'b1011, 7'h24, 1'b1);
        push(4'b0111, 7'h30, 1'b1);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("tick_latency", 32'(frame_tick), 32'd1);
        skip(1);
        check("tick_one_clock", 32'(frame_tick), 32'd0);

        // While digit 0 is lit, change seg0; only the next frame shows it.
        skip(4);
        seg0 = 5'd8;
        push(4'b1110, 7'h00, 1'b1);
        push(4'b1101, 7'h79, 1'b1);
        push(4'b1011, 7'h24, 1'b1);
        push(4'b0111, 7'h30, 1'b1);

        // Frame 2 running: set up frame 3 (blank, '-', F, blank; dp on digit 2)
        wait_tick("tick_frame2");
        skip(4);
        set_codes(5'd16, 5'd17, 5'd15, 5'd31, 4'b0100);
        push(4'b1110, 7'h7F, 1'b1);
        push(4'b1101, 7'h3F, 1'b1);
        push(4'b1011, 7'h0E, 1'b0);
        push(4'b0111, 7'h7F, 1'b1);

        // Frame 3 running: set up frame 4 (H,L,P,U), cut short in slot 2
        wait_tick("tick_frame3");
        skip(4);
        set_codes(5'd18, 5'd19, 5'd20, 5'd21, 4'b0000);
        push(4'b1110, 7'h09, 1'b1);
        push(4'b1101, 7'h47, 1'b1);
        push(4'b1011, 7'h0C, 1'b1);

        wait_tick("tick_frame4");
        skip(22);
        en = 1'b0;
        skip(1);
        check("en_off_an", 32'(an), 32'hF);
        check("en_off_cat", 32'(cat), 32'h7F);
        check("en_off_dp", 32'(dp), 32'd1);

        // Restart with r,n,o,'-' and all decimal points on
        set_codes(5'd22, 5'd23, 5'd24, 5'd17, 4'b1111);
        push(4'b1110, 7'h2F, 1'b0);
        push(4'b1101, 7'h2B, 1'b0);
        skip(3);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("restart_tick", 32'(frame_tick), 32'd1);

        // Asynchronous reset while digit 1 is lit
        skip(13);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_an", 32'(an), 32'hF);
        check("async_rst_cat", 32'(cat), 32'h7F);
        check("async_rst_dp", 32'(dp), 32'd1);
        check("async_rst_tick", 32'(frame_tick), 32'd0);
        set_codes(5'd4, 5'd5, 5'd6, 5'd7, 4'b0001);
        push(4'b1110, 7'h19, 1'b0);
        push(4'b1101, 7'h12, 1'b1);
        push(4'b1011, 7'h02, 1'b1);
        push(4'b0111, 7'h78, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_tick", 32'(frame_tick), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick("tick_after_reset");
        skip(30);
        en = 1'b0;
        skip(10);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
